// File: rtl/execute_if.sv
// Operand/control bus from read, result/forward bus, memory port and PC
// outputs of the execute stage. The slave modport is the execute stage itself.
interface execute_if;
   logic        i_valid;
   logic [15:0] src_a;
   logic [15:0] src_b;
   logic [3:0]  i_dst_reg;
   logic        i_wb_en;
   logic        i_alu_en;
   logic [3:0]  i_truth_table;
   logic [4:0]  i_alu_op;
   logic [3:0]  sh_off;
   logic        i_mem_en;
   logic        i_mem_write;
   logic [31:0] mem_addr;
   logic        i_pc_set;
   logic        i_pc_add;
   logic        i_pc_inc;
   logic [30:0] i_pc;
   logic        o_stall;
   logic [15:0] exe_out;
   logic [3:0]  exe_dst_reg;
   logic        exe_en;
   logic        o_mem_en;
   logic        o_mem_write;
   logic [31:0] o_mem_addr;
   logic [15:0] o_mem_wdata;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic [30:0] o_pc;
   logic        o_pc_redirect;

   modport slave (
      input  i_valid, src_a, src_b, i_dst_reg, i_wb_en,
      input  i_alu_en, i_truth_table, i_alu_op, sh_off,
      input  i_mem_en, i_mem_write, mem_addr,
      input  i_pc_set, i_pc_add, i_pc_inc, i_pc,
      input  mem_ready, mem_rdata,
      output o_stall, exe_out, exe_dst_reg, exe_en,
      output o_mem_en, o_mem_write, o_mem_addr, o_mem_wdata,
      output o_pc, o_pc_redirect
   );

   modport master (
      output i_valid, src_a, src_b, i_dst_reg, i_wb_en,
      output i_alu_en, i_truth_table, i_alu_op, sh_off,
      output i_mem_en, i_mem_write, mem_addr,
      output i_pc_set, i_pc_add, i_pc_inc, i_pc,
      output mem_ready, mem_rdata,
      input  o_stall, exe_out, exe_dst_reg, exe_en,
      input  o_mem_en, o_mem_write, o_mem_addr, o_mem_wdata,
      input  o_pc, o_pc_redirect
   );
endinterface

// File: rtl/execute.sv
// Execute stage: single-cycle ALU, iterative 1-bit-per-cycle shifter, memory
// access with ready handshake, and the architectural PC register.
//
// state    | meaning
// ST_IDLE  | ready to accept; single-cycle ops complete here
// ST_SHIFT | iterative shift in flight, one bit per cycle
// ST_MEM   | memory request held on the bus until mem_ready
module execute (
   input  logic     cpu_clk,
   input  logic     cpu_rst,
   execute_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_MEM   = 2'd2
   } state_t;

   state_t      state_q;
   logic [15:0] acc_q;
   logic [3:0]  cnt_q;
   logic [1:0]  sh_type_q;
   logic [3:0]  dst_q;
   logic        wb_q;

   logic [15:0] exe_out_q;
   logic [3:0]  exe_dst_q;
   logic        exe_en_q;
   logic        mem_en_q;
   logic        mem_write_q;
   logic [31:0] mem_addr_q;
   logic [15:0] mem_wdata_q;
   logic [30:0] pc_q;
   logic        redirect_q;

   logic        accept;
   logic [15:0] logic_res;
   logic [15:0] arith_res;
   logic [15:0] shift_once;
   logic [15:0] acc_step;
   logic [15:0] alu_res_d;
   logic        long_shift;
   logic [30:0] pc_d;
   logic        redirect_d;
   logic        unused_op_bit;

   function automatic logic [15:0] shift1(input logic [15:0] v, input logic [1:0] t);
      logic [15:0] r;
      case (t)
         2'b00:   r = {v[14:0], 1'b0};
         2'b01:   r = {1'b0, v[15:1]};
         2'b10:   r = {v[15], v[15:1]};
         default: r = {v[14:0], v[15]};
      endcase
      return r;
   endfunction

   assign accept        = bus.i_valid && (state_q == ST_IDLE);
   assign unused_op_bit = bus.i_alu_op[2];

   always_comb begin
      logic_res = '0;
      for (int i = 0; i < 16; i++) begin
         logic_res[i] = bus.i_truth_table[{bus.src_a[i], bus.src_b[i]}];
      end
   end

   assign arith_res  = bus.i_alu_op[0] ? (bus.src_a - bus.src_b) : (bus.src_a + bus.src_b);
   assign shift_once = shift1(bus.src_a, bus.i_alu_op[1:0]);
   assign acc_step   = shift1(acc_q, sh_type_q);
   assign long_shift = (bus.i_alu_op[4:3] == 2'b10) && (bus.sh_off >= 4'd2);

   always_comb begin
      alu_res_d = '0;
      case (bus.i_alu_op[4:3])
         2'b00:   alu_res_d = logic_res;
         2'b01:   alu_res_d = arith_res;
         2'b10:   alu_res_d = (bus.sh_off == 4'd0) ? bus.src_a : shift_once;
         default: alu_res_d = '0;
      endcase
   end

   // set beats add beats inc; 31-bit arithmetic wraps on its own
   always_comb begin
      pc_d       = pc_q;
      redirect_d = 1'b0;
      if (accept) begin
         if (bus.i_pc_set) begin
            pc_d       = bus.i_pc;
            redirect_d = 1'b1;
         end else if (bus.i_pc_add) begin
            pc_d       = pc_q + bus.i_pc;
            redirect_d = 1'b1;
         end else if (bus.i_pc_inc) begin
            pc_d       = pc_q + 31'd1;
         end
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         sh_type_q   <= '0;
         dst_q       <= '0;
         wb_q        <= 1'b0;
         exe_out_q   <= '0;
         exe_dst_q   <= '0;
         exe_en_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         pc_q        <= '0;
         redirect_q  <= 1'b0;
      end else begin
         exe_en_q   <= 1'b0;
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  dst_q <= bus.i_dst_reg;
                  wb_q  <= bus.i_wb_en;
                  if (bus.i_mem_en) begin
                     mem_en_q    <= 1'b1;
                     mem_write_q <= bus.i_mem_write;
                     mem_addr_q  <= bus.mem_addr;
                     mem_wdata_q <= bus.src_b;
                     state_q     <= ST_MEM;
                  end else if (bus.i_alu_en) begin
                     if (long_shift) begin
                        acc_q     <= shift_once;
                        cnt_q     <= bus.sh_off - 4'd1;
                        sh_type_q <= bus.i_alu_op[1:0];
                        state_q   <= ST_SHIFT;
                     end else begin
                        exe_out_q <= alu_res_d;
                        exe_dst_q <= bus.i_dst_reg;
                        exe_en_q  <= bus.i_wb_en;
                     end
                  end
               end
            end
            ST_SHIFT: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  exe_out_q <= acc_step;
                  exe_dst_q <= dst_q;
                  exe_en_q  <= wb_q;
                  state_q   <= ST_IDLE;
               end
            end
            ST_MEM: begin
               if (bus.mem_ready) begin
                  mem_en_q <= 1'b0;
                  if (!mem_write_q) begin
                     exe_out_q <= bus.mem_rdata;
                     exe_dst_q <= dst_q;
                     exe_en_q  <= wb_q;
                  end
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_stall       = (state_q != ST_IDLE);
   assign bus.exe_out       = exe_out_q;
   assign bus.exe_dst_reg   = exe_dst_q;
   assign bus.exe_en        = exe_en_q;
   assign bus.o_mem_en      = mem_en_q;
   assign bus.o_mem_write   = mem_write_q;
   assign bus.o_mem_addr    = mem_addr_q;
   assign bus.o_mem_wdata   = mem_wdata_q;
   assign bus.o_pc          = pc_q;
   assign bus.o_pc_redirect = redirect_q;

endmodule

// File: tb/tb_execute.sv
// Bench for the execute stage: vector table of single-cycle ops plus
// hand-written shift, memory, PC and reset-abort sequences, with a result scoreboard.
module tb_execute;

   logic cpu_clk = 1'b0;
   logic cpu_rst = 1'b1;

   execute_if bus();

   execute dut (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .bus     (bus)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef struct packed {
      logic [15:0] out;
      logic [3:0]  dst;
   } sb_t;

   typedef struct {
      logic [3:0]  tt;
      logic [4:0]  op;
      logic [3:0]  sh;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  dst;
      logic        wb;
      logic [15:0] exp;
   } vec_t;

   sb_t  sb[$];
   vec_t vecs[9];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_valid       = 1'b0;
      bus.src_a         = '0;
      bus.src_b         = '0;
      bus.i_dst_reg     = '0;
      bus.i_wb_en       = 1'b0;
      bus.i_alu_en      = 1'b0;
      bus.i_truth_table = '0;
      bus.i_alu_op      = '0;
      bus.sh_off        = '0;
      bus.i_mem_en      = 1'b0;
      bus.i_mem_write   = 1'b0;
      bus.mem_addr      = '0;
      bus.i_pc_set      = 1'b0;
      bus.i_pc_add      = 1'b0;
      bus.i_pc_inc      = 1'b0;
      bus.i_pc          = '0;
      bus.mem_ready     = 1'b0;
      bus.mem_rdata     = '0;
   endtask

   task automatic drive_alu(input logic [3:0] tt, input logic [4:0] op, input logic [3:0] sh,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] dst, input logic wb);
      bus.i_valid       = 1'b1;
      bus.i_alu_en      = 1'b1;
      bus.i_mem_en      = 1'b0;
      bus.i_truth_table = tt;
      bus.i_alu_op      = op;
      bus.sh_off        = sh;
      bus.src_a         = a;
      bus.src_b         = b;
      bus.i_dst_reg     = dst;
      bus.i_wb_en       = wb;
   endtask

   // every exe_en cycle must match the oldest outstanding expected result
   always @(negedge cpu_clk) begin
      if (bus.exe_en === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_exe_en: got exe_en=1 out=0x%0h expected no result", bus.exe_out);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("sb_exe_out", {16'h0, bus.exe_out}, {16'h0, e.out});
            check("sb_exe_dst", {28'h0, bus.exe_dst_reg}, {28'h0, e.dst});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;

      vecs[0] = '{4'b0110, 5'b00000, 4'd0, 16'h00FF, 16'h0F0F, 4'd3, 1'b1, 16'h0FF0};
      vecs[1] = '{4'b0000, 5'b01001, 4'd0, 16'h0000, 16'h0001, 4'd4, 1'b1, 16'hFFFF};
      vecs[2] = '{4'b0000, 5'b01000, 4'd0, 16'hFFFF, 16'h0002, 4'd5, 1'b1, 16'h0001};
      vecs[3] = '{4'b1000, 5'b00000, 4'd0, 16'hF0F0, 16'hFF00, 4'd6, 1'b1, 16'hF000};
      vecs[4] = '{4'b0000, 5'b10000, 4'd1, 16'h0001, 16'h0000, 4'd7, 1'b1, 16'h0002};
      vecs[5] = '{4'b0000, 5'b10011, 4'd0, 16'h1234, 16'h0000, 4'd8, 1'b1, 16'h1234};
      vecs[6] = '{4'b0000, 5'b11000, 4'd0, 16'hFFFF, 16'hFFFF, 4'd9, 1'b1, 16'h0000};
      vecs[7] = '{4'b1111, 5'b00000, 4'd0, 16'h1111, 16'h2222, 4'd10, 1'b0, 16'hFFFF};
      vecs[8] = '{4'b0000, 5'b10001, 4'd1, 16'h8001, 16'h0000, 4'd11, 1'b1, 16'h4000};

      clear_inputs();
      cpu_rst = 1'b1;
      repeat (3) tick();
      check("rst_pc",       {1'b0, bus.o_pc}, 32'h0);
      check("rst_stall",    {31'h0, bus.o_stall}, 32'h0);
      check("rst_exe_en",   {31'h0, bus.exe_en}, 32'h0);
      check("rst_mem_en",   {31'h0, bus.o_mem_en}, 32'h0);
      check("rst_exe_out",  {16'h0, bus.exe_out}, 32'h0);
      check("rst_redirect", {31'h0, bus.o_pc_redirect}, 32'h0);
      cpu_rst = 1'b0;
      tick();

      // single logic op: exe_en exactly one cycle
      drive_alu(vecs[0].tt, vecs[0].op, vecs[0].sh, vecs[0].a, vecs[0].b, vecs[0].dst, vecs[0].wb);
      sb.push_back('{vecs[0].exp, vecs[0].dst});
      tick();
      clear_inputs();
      check("xor_exe_en",  {31'h0, bus.exe_en}, 32'h1);
      check("xor_exe_out", {16'h0, bus.exe_out}, 32'h0FF0);
      check("xor_dst",     {28'h0, bus.exe_dst_reg}, 32'h3);
      tick();
      check("xor_exe_en_drop", {31'h0, bus.exe_en}, 32'h0);
      check("xor_out_hold",    {16'h0, bus.exe_out}, 32'h0FF0);

      // back-to-back table
      for (int i = 0; i < 9; i++) begin
         drive_alu(vecs[i].tt, vecs[i].op, vecs[i].sh, vecs[i].a, vecs[i].b, vecs[i].dst, vecs[i].wb);
         if (vecs[i].wb) sb.push_back('{vecs[i].exp, vecs[i].dst});
         tick();
         check($sformatf("vec%0d_exe_en", i), {31'h0, bus.exe_en}, {31'h0, vecs[i].wb});
         check($sformatf("vec%0d_stall", i), {31'h0, bus.o_stall}, 32'h0);
      end
      clear_inputs();
      tick();
      check("table_exe_en_drop", {31'h0, bus.exe_en}, 32'h0);

      // sar 0x8000 by 15
      drive_alu(4'h0, 5'b10010, 4'd15, 16'h8000, 16'h0, 4'd12, 1'b1);
      sb.push_back('{16'hFFFF, 4'd12});
      tick();
      clear_inputs();
      cnt = 0;
      while (bus.o_stall && cnt < 40) begin
         check("sar_no_early_en", {31'h0, bus.exe_en}, 32'h0);
         cnt++;
         tick();
      end
      check("sar_stall_cycles", cnt, 32'd14);
      check("sar_exe_en", {31'h0, bus.exe_en}, 32'h1);
      check("sar_exe_out", {16'h0, bus.exe_out}, 32'hFFFF);

      // rotl 0x8001 by 4
      drive_alu(4'h0, 5'b10011, 4'd4, 16'h8001, 16'h0, 4'd13, 1'b1);
      sb.push_back('{16'h0018, 4'd13});
      tick();
      clear_inputs();
      cnt = 0;
      while (bus.o_stall && cnt < 40) begin
         cnt++;
         tick();
      end
      check("rotl_stall_cycles", cnt, 32'd3);
      check("rotl_exe_en", {31'h0, bus.exe_en}, 32'h1);
      check("rotl_exe_out", {16'h0, bus.exe_out}, 32'h0018);

      // load with three wait cycles
      bus.i_valid   = 1'b1;
      bus.i_mem_en  = 1'b1;
      bus.i_alu_en  = 1'b1;
      bus.mem_addr  = 32'h0000_1234;
      bus.i_dst_reg = 4'd5;
      bus.i_wb_en   = 1'b1;
      sb.push_back('{16'hBEEF, 4'd5});
      tick();
      clear_inputs();
      bus.mem_addr = 32'hDEAD_0000;
      for (int w = 0; w < 3; w++) begin
         check($sformatf("load_wait%0d_mem_en", w), {31'h0, bus.o_mem_en}, 32'h1);
         check($sformatf("load_wait%0d_addr", w), bus.o_mem_addr, 32'h0000_1234);
         check($sformatf("load_wait%0d_write", w), {31'h0, bus.o_mem_write}, 32'h0);
         check($sformatf("load_wait%0d_stall", w), {31'h0, bus.o_stall}, 32'h1);
         tick();
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 16'hBEEF;
      check("load_ready_mem_en", {31'h0, bus.o_mem_en}, 32'h1);
      check("load_ready_addr", bus.o_mem_addr, 32'h0000_1234);
      tick();
      clear_inputs();
      check("load_mem_en_drop", {31'h0, bus.o_mem_en}, 32'h0);
      check("load_exe_en", {31'h0, bus.exe_en}, 32'h1);
      check("load_exe_out", {16'h0, bus.exe_out}, 32'hBEEF);
      check("load_stall_drop", {31'h0, bus.o_stall}, 32'h0);

      // store completing with ready already high
      bus.i_valid     = 1'b1;
      bus.i_mem_en    = 1'b1;
      bus.i_mem_write = 1'b1;
      bus.mem_addr    = 32'h0000_0ABC;
      bus.src_b       = 16'h5A5A;
      bus.i_wb_en     = 1'b1;
      bus.i_dst_reg   = 4'd7;
      bus.mem_ready   = 1'b1;
      tick();
      bus.i_valid = 1'b0;
      check("store_mem_en", {31'h0, bus.o_mem_en}, 32'h1);
      check("store_write", {31'h0, bus.o_mem_write}, 32'h1);
      check("store_wdata", {16'h0, bus.o_mem_wdata}, 32'h5A5A);
      check("store_addr", bus.o_mem_addr, 32'h0000_0ABC);
      tick();
      clear_inputs();
      check("store_mem_en_drop", {31'h0, bus.o_mem_en}, 32'h0);
      check("store_no_exe_en", {31'h0, bus.exe_en}, 32'h0);

      // PC sequence
      bus.i_valid  = 1'b1;
      bus.i_pc_set = 1'b1;
      bus.i_pc     = 31'h7FFF_FFFF;
      tick();
      check("pc_set_max", {1'b0, bus.o_pc}, 32'h7FFF_FFFF);
      check("pc_set_redirect", {31'h0, bus.o_pc_redirect}, 32'h1);
      bus.i_pc_set = 1'b0;
      bus.i_pc_inc = 1'b1;
      bus.i_pc     = 31'h0;
      tick();
      check("pc_inc_wrap", {1'b0, bus.o_pc}, 32'h0);
      check("pc_inc_no_redirect", {31'h0, bus.o_pc_redirect}, 32'h0);
      bus.i_pc_set = 1'b1;
      bus.i_pc     = 31'h100;
      tick();
      check("pc_set_over_inc", {1'b0, bus.o_pc}, 32'h100);
      check("pc_set_inc_redirect", {31'h0, bus.o_pc_redirect}, 32'h1);
      bus.i_pc_set = 1'b0;
      bus.i_pc_inc = 1'b0;
      bus.i_pc_add = 1'b1;
      bus.i_pc     = 31'h10;
      tick();
      clear_inputs();
      check("pc_add", {1'b0, bus.o_pc}, 32'h110);
      check("pc_add_redirect", {31'h0, bus.o_pc_redirect}, 32'h1);
      tick();
      check("pc_redirect_drop", {31'h0, bus.o_pc_redirect}, 32'h0);
      check("pc_hold", {1'b0, bus.o_pc}, 32'h110);

      // reset in the 3rd cycle of a 10-cycle shift
      drive_alu(4'h0, 5'b10000, 4'd10, 16'h0001, 16'h0, 4'd2, 1'b1);
      tick();
      clear_inputs();
      tick();
      tick();
      check("shift_stall_before_rst", {31'h0, bus.o_stall}, 32'h1);
      cpu_rst = 1'b1;
      tick();
      cpu_rst = 1'b0;
      check("rst_shift_stall", {31'h0, bus.o_stall}, 32'h0);
      check("rst_shift_exe_en", {31'h0, bus.exe_en}, 32'h0);
      check("rst_shift_pc", {1'b0, bus.o_pc}, 32'h0);
      cnt = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (bus.exe_en) cnt++;
      end
      check("rst_shift_no_result", cnt, 32'd0);

      // reset during a pending load
      bus.i_valid   = 1'b1;
      bus.i_mem_en  = 1'b1;
      bus.mem_addr  = 32'h0000_0040;
      bus.i_wb_en   = 1'b1;
      tick();
      clear_inputs();
      check("mem_pending_en", {31'h0, bus.o_mem_en}, 32'h1);
      cpu_rst = 1'b1;
      tick();
      cpu_rst = 1'b0;
      check("rst_mem_en_drop", {31'h0, bus.o_mem_en}, 32'h0);
      check("rst_mem_stall", {31'h0, bus.o_stall}, 32'h0);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 16'h7777;
      repeat (3) tick();
      clear_inputs();

      check("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/execute.md
# execute

Execute stage of the CPU pipeline, directly downstream of operand read. Accepts resolved operands (`src_a`, `src_b`) and ALU/memory/PC controls from read, performs the ALU operation, an iterative shift or a memory access, and registers the result onto the `exe_out`/`exe_dst_reg`/`exe_en` forwarding bus that read and writeback consume. Stalls read while a multi-cycle operation is in flight. Owns the architectural PC register.

## Interface
- No parameters.
- `cpu_clk`  in  1  clock; one clock domain, everything on rising edge.
- `cpu_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  read presents an operation this cycle.
- `src_a`, `src_b`  in  16  operands; `src_b` is also store data.
- `i_dst_reg`  in  4  destination register; `i_wb_en`  in  1  result is written back.
- `i_alu_en`  in  1;  `i_truth_table`  in  4;  `i_alu_op`  in  5;  `sh_off`  in  4.
- `i_mem_en`  in  1;  `i_mem_write`  in  1;  `mem_addr`  in  32.
- `i_pc_set`, `i_pc_add`, `i_pc_inc`  in  1 each;  `i_pc`  in  31.
- `o_stall`  out  1  read must hold its outputs.
- `exe_out`  out  16;  `exe_dst_reg`  out  4;  `exe_en`  out  1  result/forward bus.
- `o_mem_en`  out  1;  `o_mem_write`  out  1;  `o_mem_addr`  out  32;  `o_mem_wdata`  out  16.
- `mem_ready`  in  1;  `mem_rdata`  in  16.
- `o_pc`  out  31  PC register;  `o_pc_redirect`  out  1  one-cycle pulse after set/add.

## Operation
- Accept when `i_valid && !o_stall`. Operands, `i_dst_reg` and `i_wb_en` are latched at the accept edge.
- Class priority: `i_mem_en` over `i_alu_en`. If neither is set, no result is produced and `exe_en` stays 0.
- ALU class is selected by `i_alu_op[4:3]`:
  - 00 logic: result bit i = `i_truth_table[{a[i],b[i]}]`.
  - 01 arith: `a+b`, or `a-b` if `op[0]`; modulo 2^16.
  - 10 shift of `a` by `sh_off`, type from `op[1:0]`: 00 shl, 01 shr logical, 10 sar, 11 rotl.
  - 11 reserved: result 0x0000.
- FSM:
  - IDLE: on accept go to SHIFT if shift and `sh_off>=2`; go to MEM if mem; otherwise register the result and stay in IDLE.
  - SHIFT: accumulator shifts 1 bit per cycle. On the accept edge the accumulator is loaded already shifted once and `cnt=sh_off-1`. Each SHIFT cycle shifts once and decrements. At the edge where `cnt` reaches 0, register the result and go to IDLE.
  - MEM: hold `o_mem_en`, `o_mem_write`, `o_mem_addr`, `o_mem_wdata` stable until `mem_ready`. At the ready edge, a load registers `mem_rdata` and a store registers no result; go to IDLE.
- `o_stall = (state != IDLE)`.
- `exe_en` is a one-cycle pulse the cycle after the result is registered, gated by the latched `wb_en`. `exe_out`/`exe_dst_reg` hold their value until the next result.
- PC update on accept, priority set > add > inc:
  - set: `pc <= i_pc`.
  - add: `pc <= pc + i_pc` mod 2^31.
  - inc: `pc <= pc + 1`; 0x7FFFFFFF wraps to 0.
  - `o_pc_redirect` pulses for set/add only.

## Timing
- Reset: state IDLE, all outputs 0 (`o_pc=0`, `o_stall=0`, `exe_en=0`, `o_mem_en=0`). Reset mid-SHIFT or mid-MEM aborts immediately: `o_mem_en` drops the next cycle and no result is produced.
- Logic/arith/shift with `sh_off<=1`, accepted at edge N: `exe_en` high in cycle N+1. `sh_off=0` passes `a` unchanged.
- Shift with `sh_off=k>=2`: `o_stall` high in cycles N+1..N+k-1; `exe_en` high in cycle N+k.
- Memory: `o_mem_en` high from cycle N+1 until the cycle `mem_ready` is sampled (inclusive). A `mem_ready` already high in cycle N+1 completes in one cycle. A load gives `exe_en` the cycle after ready.
- Back-to-back single-cycle ops: one accepted per cycle, `exe_en` continuous.

## Test plan
- Reset, then logic op with tt=0b0110, a=0x00FF, b=0x0F0F, wb_en=1, dst=3 -> next cycle `exe_out`=0x0FF0, `exe_dst_reg`=3, `exe_en`=1 for exactly 1 cycle.
- Sub with a=0x0000, b=0x0001 -> 0xFFFF. Add 0xFFFF+0x0002 -> 0x0001. Back-to-back: two consecutive `exe_en` cycles.
- sar a=0x8000, `sh_off`=15 -> `o_stall` high 14 cycles, then `exe_out`=0xFFFF. rotl a=0x8001 by 4 -> 0x0018 after 4 cycles.
- Load addr 0x00001234, `mem_ready` after 3 wait cycles, rdata 0xBEEF -> addr held stable throughout, `exe_out`=0xBEEF. Store -> `o_mem_wdata`=`src_b`, no `exe_en`.
- PC: inc from 0x7FFFFFFF -> 0. `pc_set`+`pc_inc` together with `i_pc`=0x100 -> 0x100 and `o_pc_redirect` pulse. add 0x10 -> 0x110.
- `cpu_rst` asserted in the 3rd cycle of a 10-cycle shift -> IDLE next cycle, `o_stall`=0, `exe_en` never asserted.
